// File: rtl/alu_seq_top_if.sv
// alu_seq_if: board-facing bundle of the ALU sequencer.
//   i_sw    switch data (A and B use all bits, opcode uses the low NB_OP bits)
//   i_btn   raw buttons, [0]=enter, [1]=clear; asynchronous and bouncy
//   o_led   registered result
//   o_zero  result == 0, registered together with o_led
//   o_ovf   signed overflow of ADD/SUB, registered together with o_led
//   o_valid result strobe
//   o_state current sequencer state (00=A, 01=B, 10=OP, 11=EXEC)
// Handshake: o_valid is a push-only strobe with no ready. It is high for
// exactly one clock, in the cycle in which o_led/o_zero/o_ovf first show a
// new result. The consumer must sample on that cycle. Between strobes the
// outputs hold their last value.
interface alu_seq_if #(
  parameter int NB_AB = 8
);
  logic [NB_AB-1:0] i_sw;
  logic [1:0]       i_btn;
  logic [NB_AB-1:0] o_led;
  logic             o_zero;
  logic             o_ovf;
  logic             o_valid;
  logic [1:0]       o_state;

  modport master (
    output i_sw, i_btn,
    input  o_led, o_zero, o_ovf, o_valid, o_state
  );

  modport slave (
    input  i_sw, i_btn,
    output o_led, o_zero, o_ovf, o_valid, o_state
  );
endinterface

// File: rtl/alu_seq_top.sv
// alu_seq_debounce: one button path. A 2-flop synchroniser feeds a counter
// that accepts a new level after DEBOUNCE_N consecutive samples differing
// from the accepted level. Any sample equal to the accepted level restarts
// the count. evt is a 1-cycle pulse on a rising edge of the accepted level.
//   clock, rst  clock and asynchronous active-high reset
//   btn         raw button input
//   evt         1-cycle press event
module alu_seq_debounce #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic btn,
  output logic evt
);
  localparam int CW = (DEBOUNCE_N < 2) ? 1 : $clog2(DEBOUNCE_N);

  logic [1:0]    sync_q;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_d <= level;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_N - 1)) begin
        // DEBOUNCE_N-th consecutive differing sample: accept it.
        cnt   <= '0;
        level <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evt = level & ~level_d;
endmodule

// alu_seq_top: sequenced ALU entry. The debounced enter button loads A, B,
// then the opcode from the switches; one cycle later the result and flags
// are registered and o_valid strobes. Clear returns to the A step.
//   clock    system clock, rising edge
//   i_reset  asynchronous active-high reset (released synchronously inside)
//   bus      alu_seq_if slave: switches, buttons, LEDs, flags, state
module alu_seq_top #(
  parameter int NB_AB      = 8,
  parameter int NB_OP      = 6,
  parameter int NB_SH      = 3,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clock,
  input  logic       i_reset,
  alu_seq_if.slave   bus
);
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam int MSB = NB_AB - 1;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_EXEC = 2'b11
  } state_t;

  // Reset asserts asynchronously, releases on a clock edge so no flop
  // sees reset removal near its active edge.
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst = rst_sync[1];

  logic ent_evt;
  logic clr_evt;

  alu_seq_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_enter (
    .clock (clock),
    .rst   (rst),
    .btn   (bus.i_btn[0]),
    .evt   (ent_evt)
  );

  alu_seq_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_clear (
    .clock (clock),
    .rst   (rst),
    .btn   (bus.i_btn[1]),
    .evt   (clr_evt)
  );

  state_t           state;
  state_t           state_nx;
  logic             load_a;
  logic             load_b;
  logic             load_op;
  logic             exec;
  logic [NB_AB-1:0] reg_a;
  logic [NB_AB-1:0] reg_b;
  logic [NB_OP-1:0] reg_op;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= state_nx;
  end

  // Clear has priority over enter; events seen in S_EXEC are ignored.
  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_op  = 1'b0;
    exec     = 1'b0;
    case (state)
      S_A: begin
        if (clr_evt) state_nx = S_A;
        else if (ent_evt) begin
          load_a   = 1'b1;
          state_nx = S_B;
        end
      end
      S_B: begin
        if (clr_evt) state_nx = S_A;
        else if (ent_evt) begin
          load_b   = 1'b1;
          state_nx = S_OP;
        end
      end
      S_OP: begin
        if (clr_evt) state_nx = S_A;
        else if (ent_evt) begin
          load_op  = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        exec     = 1'b1;
        state_nx = S_A;
      end
      default: state_nx = S_A;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
    end else begin
      if (load_a)  reg_a  <= bus.i_sw;
      if (load_b)  reg_b  <= bus.i_sw;
      if (load_op) reg_op <= bus.i_sw[NB_OP-1:0];
    end
  end

  logic [NB_AB-1:0] alu_res;
  logic             alu_ovf;
  logic [NB_SH-1:0] sh;

  assign sh = reg_b[NB_SH-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (reg_op)
      OP_ADD: begin
        alu_res = reg_a + reg_b;
        alu_ovf = (reg_a[MSB] == reg_b[MSB]) && (alu_res[MSB] != reg_a[MSB]);
      end
      OP_SUB: begin
        alu_res = reg_a - reg_b;
        alu_ovf = (reg_a[MSB] != reg_b[MSB]) && (alu_res[MSB] != reg_a[MSB]);
      end
      OP_AND:  alu_res = reg_a & reg_b;
      OP_OR:   alu_res = reg_a | reg_b;
      OP_XOR:  alu_res = reg_a ^ reg_b;
      OP_NOR:  alu_res = ~(reg_a | reg_b);
      OP_SRA:  alu_res = $unsigned($signed(reg_a) >>> sh);
      OP_SRL:  alu_res = reg_a >> sh;
      default: alu_res = '0;
    endcase
  end

  logic [NB_AB-1:0] led_q;
  logic             zero_q;
  logic             ovf_q;
  logic             valid_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= exec;
      if (exec) begin
        led_q  <= alu_res;
        zero_q <= (alu_res == '0);
        ovf_q  <= alu_ovf;
      end
    end
  end

  assign bus.o_led   = led_q;
  assign bus.o_zero  = zero_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_valid = valid_q;
  assign bus.o_state = state;
endmodule
